brlshift_pipe: RTL and testbench
================================

Name: brlshift_pipe

Overview:
Parametrised, pipelined successor to the GPU/DSP barrel shifter. It takes an operand, a shift amount and a mode, and produces the shifted result plus carry-out. It supports logical, arithmetic and rotate modes at any word width. It sits between the register-file read stage and the ALU write-back mux, with valid/ready handshakes on both sides so the pipeline can stall.

Parameters:
DW, 32, operand/result width in bits; power of two, 8..64.
SW, $clog2(DW), shift-amount width; derived, must not be overridden.
STAGES, 2, register stages from input to output; legal range 1..SW; sets latency.

Ports:
sys_clk  input  1  system clock; all state updates on rising edge.
resetl  input  1  asynchronous active-low reset; deasserts synchronously to sys_clk.
in_valid  input  1  operand/amount/mode valid this cycle.
in_ready  output  1  block accepts the input when in_valid & in_ready.
in_data  input  DW  operand.
in_amt  input  SW  shift/rotate count, unsigned, 0..DW-1.
in_mode  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, 101..111 reserved.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  DW  shifted result.
out_carry  output  1  carry-out per the mode rules below.

Behaviour:
- Reset (resetl low, asynchronous): every stage valid bit cleared; out_valid=0, out_data=0, out_carry=0. in_ready=1 from the first clock after release. In-flight operations are discarded with no partial output.
- Pipeline: STAGES register slices. The log2 shifter levels are split across the slices; slice partitioning is free. Each slice holds a valid bit, partial result, amt, mode, and carry/sign state.
- Latency: exactly STAGES cycles from the accepting edge to out_valid when out_ready stays high. Throughput is 1 op/cycle.
- Slice k loads when it is empty or its contents advance this cycle. The last slice advances when out_valid & out_ready.
- in_ready = first slice empty or first slice advancing. Bubbles collapse: a stalled output does not block upstream slices that still have an empty slot ahead of them.
- out_data, out_carry and out_valid are held stable while out_valid & !out_ready.
- Results (a = in_amt, d = in_data):
  - LSL: d<<a, zero fill; carry = d[DW-a] if a>0 else 0.
  - LSR: d>>a, zero fill; carry = d[a-1] if a>0 else 0.
  - ASR: d>>a, filled with d[DW-1]; carry = d[a-1] if a>0 else 0.
  - ROR: rotate right by a; carry = out_data[DW-1].
  - ROL: rotate left by a; carry = out_data[0].
  - Reserved modes: out_data = d, carry = 0, no error flag.
- a=0 in any legal mode: out_data = d. Carry is 0 for shift modes and per the formula for rotates.
- Simultaneous accept and output in the same cycle is legal when full and keeps full throughput.
- No reordering; results exit in acceptance order.

Optional Feature:
Macro BRL_FLAGS_EN.
- Defined: adds outputs out_zero (1 bit, out_data==0) and out_neg (1 bit, out_data[DW-1]). Both are registered alongside out_data with the same latency, hold and reset-to-0 rules.
- Not defined: the ports are absent and no flag logic is built.

Test Plan:
1. DW=32, STAGES=2; d=0x80000001, a=1, LSL, out_ready=1 -> 2 cycles later out_data=0x00000002, out_carry=1.
2. d=0x80000000, a=4, ASR -> out_data=0xF8000000, carry=0. Same with LSR -> 0x08000000, carry=0.
3. d=0x12345678, a=8: ROR -> 0x78123456, carry=0. ROL -> 0x34567812, carry=0. With a=0 on any mode -> 0x12345678.
4. Back-to-back 8 ops with out_ready held low for 3 cycles mid-stream -> in_ready drops once both slices are full; the held output is stable; all 8 results emerge in order with none lost or duplicated.
5. Pull resetl low with 2 ops in flight -> out_valid=0 and out_data=0 immediately. After release no stale result appears and the next op has normal latency.
6. BRL_FLAGS_EN defined: d=0x00000001, a=1, LSR -> out_data=0, out_zero=1, out_neg=0, out_carry=1.

Source files
------------

// File: rtl/brlshift_pipe.sv
// brlshift_pipe -- pipelined barrel shifter with valid/ready handshakes.
//
// Shifts or rotates an operand by an unsigned amount and reports the
// carry-out. The log2(DW) shifter levels are spread evenly over STAGES
// register slices. Each slice holds a valid bit, the partial result, the
// remaining amount/mode and the running carry.
//
// Parameters:
//   DW      operand/result width (power of two, 8..64)
//   STAGES  register slices from input to output (1..SW), equals latency
//   SW      shift-amount width, derived from DW (not overridable)
//
// Ports:
//   sys_clk    clock, rising edge
//   resetl     asynchronous active-low reset
//   in_valid   input operation valid
//   in_ready   block accepts input when in_valid & in_ready
//   in_data    operand
//   in_amt     shift/rotate count 0..DW-1
//   in_mode    000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others pass-through
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_carry  carry-out
//   out_zero   (BRL_FLAGS_EN only) out_data == 0
//   out_neg    (BRL_FLAGS_EN only) out_data[DW-1]
//
// Optional feature macro: BRL_FLAGS_EN adds the out_zero/out_neg flags.
module brlshift_pipe #(
   parameter int  DW     = 32,
   parameter int  STAGES = 2,
   localparam int SW     = $clog2(DW)
) (
   input  logic          sys_clk,
   input  logic          resetl,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [SW-1:0] in_amt,
   input  logic [2:0]    in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_carry
`ifdef BRL_FLAGS_EN
   ,
   output logic          out_zero,
   output logic          out_neg
`endif
);

   localparam logic [2:0] MODE_LSL = 3'b000;
   localparam logic [2:0] MODE_LSR = 3'b001;
   localparam logic [2:0] MODE_ASR = 3'b010;
   localparam logic [2:0] MODE_ROR = 3'b011;
   localparam logic [2:0] MODE_ROL = 3'b100;

   // Per-level combinational outputs of the shifter network.
   logic [DW-1:0] lvl_out_data  [SW];
   logic          lvl_out_carry [SW];
   logic [SW-1:0] lvl_amt       [SW];
   logic [2:0]    lvl_mode      [SW];

   // Slice registers.
   logic [DW-1:0] data_reg  [STAGES];
   logic          carry_reg [STAGES];
   logic [SW-1:0] amt_reg   [STAGES];
   logic [2:0]    mode_reg  [STAGES];
   logic          valid_reg [STAGES];
   logic          load      [STAGES];
   logic          adv       [STAGES];

   logic final_carry;

   genvar gi;

   // Shifter levels: level gi shifts by 2**gi when amount bit gi is set.
   // Level gi belongs to slice floor(gi*STAGES/SW); the first level of a
   // slice reads the previous slice register (or the block inputs).
   generate
      for (gi = 0; gi < SW; gi++) begin : g_lvl
         localparam int SH    = 1 << gi;
         localparam int SL    = (gi * STAGES) / SW;
         localparam int FIRST = (SL * SW + STAGES - 1) / STAGES;

         logic [DW-1:0] d_i;
         logic          c_i;
         logic [DW-1:0] d_o;
         logic          c_o;

         if (gi == FIRST) begin : g_head
            if (SL == 0) begin : g_from_in
               assign d_i          = in_data;
               assign c_i          = 1'b0;
               assign lvl_amt[gi]  = in_amt;
               assign lvl_mode[gi] = in_mode;
            end else begin : g_from_reg
               assign d_i          = data_reg[SL-1];
               assign c_i          = carry_reg[SL-1];
               assign lvl_amt[gi]  = amt_reg[SL-1];
               assign lvl_mode[gi] = mode_reg[SL-1];
            end
         end else begin : g_chain
            assign d_i          = lvl_out_data[gi-1];
            assign c_i          = lvl_out_carry[gi-1];
            assign lvl_amt[gi]  = lvl_amt[gi-1];
            assign lvl_mode[gi] = lvl_mode[gi-1];
         end

         // The carry of a shift is the last bit pushed out; a later level
         // that shifts again overwrites it with the bit further along.
         always_comb begin
            d_o = d_i;
            c_o = c_i;
            if (lvl_amt[gi][gi]) begin
               case (lvl_mode[gi])
                  MODE_LSL: begin
                     c_o = d_i[DW-SH];
                     d_o = d_i << SH;
                  end
                  MODE_LSR: begin
                     c_o = d_i[SH-1];
                     d_o = d_i >> SH;
                  end
                  MODE_ASR: begin
                     c_o = d_i[SH-1];
                     d_o = $signed(d_i) >>> SH;
                  end
                  MODE_ROR: d_o = {d_i[SH-1:0], d_i[DW-1:SH]};
                  MODE_ROL: d_o = {d_i[DW-SH-1:0], d_i[DW-1:DW-SH]};
                  default:  d_o = d_i;
               endcase
            end
         end

         assign lvl_out_data[gi]  = d_o;
         assign lvl_out_carry[gi] = c_o;
      end
   endgenerate

   // Rotate carry depends only on the finished result.
   always_comb begin
      final_carry = lvl_out_carry[SW-1];
      case (lvl_mode[SW-1])
         MODE_ROR: final_carry = lvl_out_data[SW-1][DW-1];
         MODE_ROL: final_carry = lvl_out_data[SW-1][0];
         default:  final_carry = lvl_out_carry[SW-1];
      endcase
   end

   // Register slices with per-slice handshake: a slice loads when empty or
   // when its content moves on this cycle, so bubbles collapse.
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_slice
         localparam int LAST = ((gi + 1) * SW + STAGES - 1) / STAGES - 1;

         logic up_valid;
         logic c_next;

         if (gi == 0) begin : g_up_in
            assign up_valid = in_valid;
         end else begin : g_up_reg
            assign up_valid = valid_reg[gi-1];
         end

         if (gi == STAGES - 1) begin : g_tail
            assign adv[gi] = valid_reg[gi] & out_ready;
            assign c_next  = final_carry;
         end else begin : g_mid
            assign adv[gi] = valid_reg[gi] & load[gi+1];
            assign c_next  = lvl_out_carry[LAST];
         end

         assign load[gi] = ~valid_reg[gi] | adv[gi];

         always_ff @(posedge sys_clk or negedge resetl) begin
            if (!resetl) begin
               valid_reg[gi] <= 1'b0;
               data_reg[gi]  <= '0;
               carry_reg[gi] <= 1'b0;
               amt_reg[gi]   <= '0;
               mode_reg[gi]  <= '0;
            end else if (load[gi]) begin
               valid_reg[gi] <= up_valid;
               if (up_valid) begin
                  data_reg[gi]  <= lvl_out_data[LAST];
                  carry_reg[gi] <= c_next;
                  amt_reg[gi]   <= lvl_amt[LAST];
                  mode_reg[gi]  <= lvl_mode[LAST];
               end
            end
         end
      end
   endgenerate

   assign in_ready  = load[0];
   assign out_valid = valid_reg[STAGES-1];
   assign out_data  = data_reg[STAGES-1];
   assign out_carry = carry_reg[STAGES-1];

`ifdef BRL_FLAGS_EN
   logic zero_reg;
   logic neg_reg;
   logic tail_up_valid;

   generate
      if (STAGES == 1) begin : g_fl_in
         assign tail_up_valid = in_valid;
      end else begin : g_fl_reg
         assign tail_up_valid = valid_reg[STAGES-2];
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         zero_reg <= 1'b0;
         neg_reg  <= 1'b0;
      end else if (load[STAGES-1] && tail_up_valid) begin
         zero_reg <= (lvl_out_data[SW-1] == '0);
         neg_reg  <= lvl_out_data[SW-1][DW-1];
      end
   end

   assign out_zero = zero_reg;
   assign out_neg  = neg_reg;
`endif

endmodule

// File: tb/tb_brlshift_pipe.sv
// tb_brlshift_pipe -- self-checking bench for brlshift_pipe (DW=32, STAGES=2).
// Directed cases with hand-computed results, then randomized traffic checked
// against an arithmetic reference model through an in-order expectation queue.
module tb_brlshift_pipe;

   localparam int DW     = 32;
   localparam int STAGES = 2;

   localparam logic [2:0] LSL = 3'd0;
   localparam logic [2:0] LSR = 3'd1;
   localparam logic [2:0] ASR = 3'd2;
   localparam logic [2:0] ROR = 3'd3;
   localparam logic [2:0] ROL = 3'd4;

   typedef struct packed {
      logic [31:0] data;
      logic        carry;
   } exp_t;

   logic        sys_clk   = 1'b0;
   logic        resetl    = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [31:0] in_data   = '0;
   logic [4:0]  in_amt    = '0;
   logic [2:0]  in_mode   = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_carry;
`ifdef BRL_FLAGS_EN
   logic        out_zero;
   logic        out_neg;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   logic        hold_pending = 1'b0;
   logic [31:0] hold_data    = '0;
   logic        hold_carry   = 1'b0;
   logic        seen_out     = 1'b0;
   logic        accepted     = 1'b0;
   logic        ready_seen   = 1'b0;

   always #5 sys_clk = ~sys_clk;

   brlshift_pipe #(.DW(DW), .STAGES(STAGES)) dut (
      .sys_clk   (sys_clk),
      .resetl    (resetl),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry)
`ifdef BRL_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the mode rules, using 64-bit arithmetic.
   function automatic exp_t model(input logic [31:0] d, input int a, input logic [2:0] m);
      exp_t               e;
      logic [63:0]        x;
      logic [63:0]        r;
      logic signed [63:0] s;
      logic               c;
      x = {32'h0, d};
      s = {{32{d[31]}}, d};
      c = 1'b0;
      case (m)
         LSL: begin
            r = (x << a) & 64'hFFFF_FFFF;
            if (a > 0) c = x[32-a];
         end
         LSR: begin
            r = x >> a;
            if (a > 0) c = x[a-1];
         end
         ASR: begin
            r = 64'(s >>> a) & 64'hFFFF_FFFF;
            if (a > 0) c = x[a-1];
         end
         ROR: begin
            r = ((x >> a) | (x << (32 - a))) & 64'hFFFF_FFFF;
            c = r[31];
         end
         ROL: begin
            r = ((x << a) | (x >> (32 - a))) & 64'hFFFF_FFFF;
            c = r[0];
         end
         default: r = x;
      endcase
      e.data  = r[31:0];
      e.carry = c;
      return e;
   endfunction

   // One clock: drive at negedge, sample 1 time unit later, then wait posedge.
   task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic [2:0] m, input logic ordy, input exp_t e);
      exp_t got;
      @(negedge sys_clk);
      in_valid  = v;
      in_data   = d;
      in_amt    = a;
      in_mode   = m;
      out_ready = ordy;
      #1;
      if (hold_pending) begin
         chk("hold_valid", 64'(out_valid), 64'(1'b1));
         chk("hold_data",  64'(out_data),  64'(hold_data));
         chk("hold_carry", 64'(out_carry), 64'(hold_carry));
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_carry   = out_carry;
      seen_out     = out_valid;
      ready_seen   = in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 64'(1'b1), 64'(1'b0));
         end else begin
            got = exp_q.pop_front();
            chk("out_data",  64'(out_data),  64'(got.data));
            chk("out_carry", 64'(out_carry), 64'(got.carry));
`ifdef BRL_FLAGS_EN
            chk("out_zero", 64'(out_zero), 64'(got.data == 32'h0));
            chk("out_neg",  64'(out_neg),  64'(got.data[31]));
`endif
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) exp_q.push_back(e);
      @(posedge sys_clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 5'd0, 3'd0, ordy, '0);
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m, input exp_t e);
      int n;
      n = 0;
      do begin
         step(1'b1, d, a, m, 1'b1, e);
         n++;
      end while (!accepted && n < 20);
      if (!accepted) chk("send_timeout", 64'(1'b0), 64'(1'b1));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         idle(1'b1);
         n++;
      end
      chk(tag, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic latency(input string tag);
      int n;
      n = 0;
      do begin
         idle(1'b1);
         n++;
      end while (!seen_out && n < 20);
      chk(tag, 64'(n), 64'(STAGES));
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  a;
      logic [2:0]  m;
      int          i;
      int          cyc;
      logic [31:0] ops [8];

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_out_carry", 64'(out_carry), 64'(1'b0));
`ifdef BRL_FLAGS_EN
      chk("rst_out_zero", 64'(out_zero), 64'(1'b0));
      chk("rst_out_neg",  64'(out_neg),  64'(1'b0));
`endif
      @(negedge sys_clk);
      resetl = 1'b1;
      idle(1'b1);
      chk("in_ready_after_reset", 64'(ready_seen), 64'(1'b1));

      // LSL with carry, and latency
      send(32'h8000_0001, 5'd1, LSL, '{32'h0000_0002, 1'b1});
      latency("latency_lsl");

      // Directed results, back to back
      send(32'h8000_0000, 5'd4,  ASR,    '{32'hF800_0000, 1'b0});
      send(32'h8000_0000, 5'd4,  LSR,    '{32'h0800_0000, 1'b0});
      send(32'h1234_5678, 5'd8,  ROR,    '{32'h7812_3456, 1'b0});
      send(32'h1234_5678, 5'd8,  ROL,    '{32'h3456_7812, 1'b0});
      send(32'h1234_5678, 5'd0,  LSL,    '{32'h1234_5678, 1'b0});
      send(32'h1234_5678, 5'd0,  ASR,    '{32'h1234_5678, 1'b0});
      send(32'h1234_5678, 5'd0,  ROR,    '{32'h1234_5678, 1'b0});
      send(32'h8000_0001, 5'd0,  ROL,    '{32'h8000_0001, 1'b1});
      send(32'h8000_0000, 5'd1,  ROL,    '{32'h0000_0001, 1'b1});
      send(32'h8000_0000, 5'd31, ASR,    '{32'hFFFF_FFFF, 1'b0});
      send(32'h0000_0001, 5'd31, LSL,    '{32'h8000_0000, 1'b0});
      send(32'h0000_0003, 5'd31, LSL,    '{32'h8000_0000, 1'b1});
      send(32'h0000_0001, 5'd1,  LSR,    '{32'h0000_0000, 1'b1});
      send(32'hDEAD_BEEF, 5'd3,  3'd5,   '{32'hDEAD_BEEF, 1'b0});
      send(32'hDEAD_BEEF, 5'd7,  3'd7,   '{32'hDEAD_BEEF, 1'b0});
      drain("drain_directed");

      // Back-to-back 8 ops with a 3-cycle output stall
      for (int k = 0; k < 8; k++) ops[k] = $urandom;
      i = 0;
      cyc = 0;
      while (i < 8 && cyc < 40) begin
         step(1'b1, ops[i], 5'(i + 1), ROR, !(cyc >= 3 && cyc < 6), model(ops[i], i + 1, ROR));
         if (cyc == 5) chk("in_ready_full_stall", 64'(ready_seen), 64'(1'b0));
         if (cyc == 6) chk("in_ready_resume",     64'(ready_seen), 64'(1'b1));
         if (accepted) i++;
         cyc++;
      end
      chk("stream_all_accepted", 64'(i), 64'(8));
      drain("drain_stream");

      // Reset with two operations in flight
      send(32'h0000_00F0, 5'd4, LSL, '{32'h0000_0F00, 1'b0});
      send(32'h0000_00F0, 5'd4, LSR, '{32'h0000_000F, 1'b0});
      #3;
      resetl = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("midrst_out_data",  64'(out_data),  64'(0));
      chk("midrst_out_carry", 64'(out_carry), 64'(1'b0));
      exp_q.delete();
      hold_pending = 1'b0;
      in_valid     = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      resetl = 1'b1;
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         chk("no_stale_out", 64'(seen_out), 64'(1'b0));
      end
      send(32'h0000_0010, 5'd2, ROR, '{32'h0000_0004, 1'b0});
      latency("latency_after_reset");

`ifdef BRL_FLAGS_EN
      send(32'h0000_0001, 5'd1, LSR, '{32'h0000_0000, 1'b1});
      send(32'h0000_0001, 5'd31, ROR, '{32'h0000_0002, 1'b0});
      send(32'h4000_0000, 5'd1, LSL, '{32'h8000_0000, 1'b0});
      drain("drain_flags");
`endif

      // Randomized traffic with random bubbles and back-pressure
      for (int k = 0; k < 300; k++) begin
         d = $urandom;
         a = 5'($urandom_range(0, 31));
         m = 3'($urandom_range(0, 7));
         step($urandom_range(0, 3) != 0, d, a, m, $urandom_range(0, 3) != 0, model(d, int'(a), m));
      end
      drain("drain_random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
